// File: rtl/fc_img_loader.sv
`default_nettype none
// ============================================================================
// Module   : fc_img_loader
// Purpose  : Upstream feeder for the fully-connected classifier stage.
//            Collects one grayscale frame from a valid/ready pixel stream and
//            stores each pixel already converted to the classifier's
//            INT_BITS.FRC_BITS fixed-point format. Bursts the stored frame
//            into the classifier image-load port (start/address/data, one
//            pixel per cycle). Captures the predicted digit on the
//            classifier's result strobe and holds it on a valid/ready port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   s_pix_valid_i  input pixel valid
//   s_pix_ready_o  input pixel accepted when valid & ready
//   s_pix_data_i   unsigned pixel [PIX_W]
//   s_pix_last_i   marks last pixel of a frame
//   fc_start_o     classifier start, high on first burst cycle only
//   fc_x_o         classifier image address [ADDR_OUT]
//   fc_din_o       converted pixel [INT_BITS+FRC_BITS]
//   fc_num_i       classifier predicted digit [INT_BITS]
//   fc_rdy_i       classifier one-cycle result strobe
//   res_valid_o    captured result available
//   res_ready_i    result consumer ready
//   res_num_o      captured digit [INT_BITS]
//   frame_err_o    one-cycle pulse: malformed frame dropped
//   busy_o         launcher not idle
// ----------------------------------------------------------------------------
// Build option:
//   FC_IMG_SIGNED_NORM_EN  when defined, pixels map to [-1,1) instead of
//                          the default [0,1).
// ============================================================================
module fc_img_loader #(
  parameter int INT_BITS = 8,
  parameter int FRC_BITS = 8,   // must be >= PIX_W
  parameter int PIX_W    = 8,
  parameter int WIDTH    = 784,
  parameter int ADDR_OUT = 10   // 2**ADDR_OUT must be >= WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  // pixel stream
  input  logic                         s_pix_valid_i,
  output logic                         s_pix_ready_o,
  input  logic [PIX_W-1:0]             s_pix_data_i,
  input  logic                         s_pix_last_i,
  // classifier image-load port
  output logic                         fc_start_o,
  output logic [ADDR_OUT-1:0]          fc_x_o,
  output logic [INT_BITS+FRC_BITS-1:0] fc_din_o,
  input  logic [INT_BITS-1:0]          fc_num_i,
  input  logic                         fc_rdy_i,
  // result port
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic [INT_BITS-1:0]          res_num_o,
  // status
  output logic                         frame_err_o,
  output logic                         busy_o
);

  localparam int DW    = INT_BITS + FRC_BITS;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ADDR_OUT-1:0] LAST_ADDR = ADDR_OUT'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREP  = 2'd1,
    ST_BURST = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_OUT-1:0] pix_cnt;
  logic                frame_full;
  logic                accept;
  logic [DW-1:0]       conv_pix;

  // Frame store: written by the collector, read synchronously by the launcher.
  logic [DW-1:0]       frame_mem [WIDTH];
  logic [DW-1:0]       rd_data;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;

  // --------------------------------------------------------------------------
  // Pixel conversion
  // --------------------------------------------------------------------------
`ifdef FC_IMG_SIGNED_NORM_EN
  // Flipping the MSB turns the offset-binary pixel into two's complement
  // (pix - 2^(PIX_W-1)); one extra left shift scales the range to [-1,1).
  logic [PIX_W-1:0] centered;
  logic [DW-1:0]    centered_ext;

  assign centered     = {~s_pix_data_i[PIX_W-1], s_pix_data_i[PIX_W-2:0]};
  assign centered_ext = {{(DW-PIX_W){centered[PIX_W-1]}}, centered};
  assign conv_pix     = centered_ext << (FRC_BITS - PIX_W + 1);
`else
  // Pixel lands in the top of the fraction field: pix / 2^PIX_W in [0,1).
  assign conv_pix = DW'(s_pix_data_i) << (FRC_BITS - PIX_W);
`endif

  // --------------------------------------------------------------------------
  // Handshake and status
  // --------------------------------------------------------------------------
  // Gated by rst_n so that nothing looks accepted while reset is held.
  assign s_pix_ready_o = rst_n & ~frame_full & (state != ST_BURST);
  assign accept        = s_pix_valid_i & s_pix_ready_o;
  assign busy_o        = (state != ST_IDLE);

  // The read register holds the burst word; outside the burst it is stale,
  // so the port is forced to zero.
  assign fc_din_o = (state == ST_BURST) ? rd_data : '0;

  // pix_cnt and fc_x_o never exceed WIDTH-1, so dropping upper bits is safe.
  assign wr_idx = pix_cnt[IDX_W-1:0];

  // Read address runs one ahead of fc_x_o: address 0 is fetched while in PREP
  // (and in every other non-burst cycle), k+1 while presenting word k.
  always_comb begin
    rd_idx = '0;
    if (state == ST_BURST && fc_x_o != LAST_ADDR) begin
      rd_idx = fc_x_o[IDX_W-1:0] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      frame_mem[wr_idx] <= conv_pix;
    end
    rd_data <= frame_mem[rd_idx];
  end

  // --------------------------------------------------------------------------
  // Collector, launcher FSM and result holder
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pix_cnt     <= '0;
      frame_full  <= 1'b0;
      frame_err_o <= 1'b0;
      fc_start_o  <= 1'b0;
      fc_x_o      <= '0;
      res_valid_o <= 1'b0;
      res_num_o   <= '0;
    end else begin
      frame_err_o <= 1'b0;

      // Collector: a frame is good only if 'last' coincides with the final
      // slot; any other placement of 'last' drops the frame.
      if (accept) begin
        if (pix_cnt == LAST_ADDR) begin
          pix_cnt <= '0;
          if (s_pix_last_i) begin
            frame_full <= 1'b1;
          end else begin
            frame_err_o <= 1'b1;
          end
        end else if (s_pix_last_i) begin
          pix_cnt     <= '0;
          frame_err_o <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end

      // Result consumed; a capture in WAIT below cannot coincide because a
      // launch only happens with the result slot empty.
      if (res_valid_o && res_ready_i) begin
        res_valid_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          // Uses the registered res_valid_o, so a handshake completing this
          // cycle delays the launch by one cycle.
          if (frame_full && !res_valid_o) begin
            state <= ST_PREP;
          end
        end
        ST_PREP: begin
          state      <= ST_BURST;
          fc_start_o <= 1'b1;
          fc_x_o     <= '0;
        end
        ST_BURST: begin
          fc_start_o <= 1'b0;
          if (fc_x_o == LAST_ADDR) begin
            state      <= ST_WAIT;
            fc_x_o     <= '0;
            frame_full <= 1'b0;   // buffer free for the next frame
          end else begin
            fc_x_o <= fc_x_o + 1'b1;
          end
        end
        ST_WAIT: begin
          if (fc_rdy_i) begin
            res_num_o   <= fc_num_i;
            res_valid_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fc_img_loader.md
Name: fc_img_loader

Overview:
Upstream feeder for the fully-connected classifier stage. It collects one grayscale frame from a valid/ready pixel stream and converts each pixel to the INT_BITS+FRC_BITS fixed-point format. It then bursts the frame into the classifier's image-load port as start/address/data, one pixel per cycle. Afterwards it captures the predicted digit on the classifier's ready pulse and offers it on a valid/ready result port.

Parameters:
INT_BITS, 8, integer bits of classifier fixed-point word
FRC_BITS, 8, fractional bits; must be >= PIX_W
PIX_W, 8, input pixel width (unsigned)
WIDTH, 784, pixels per frame (28x28)
ADDR_OUT, 10, frame address width; must satisfy 2**ADDR_OUT >= WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_pix_valid_i  in  1  input pixel valid
s_pix_ready_o  out  1  input pixel accepted when valid&ready
s_pix_data_i  in  PIX_W  unsigned pixel
s_pix_last_i  in  1  marks last pixel of frame
fc_start_o  out  1  classifier start, high only on first burst cycle
fc_x_o  out  ADDR_OUT  classifier image address
fc_din_o  out  INT_BITS+FRC_BITS  converted pixel
fc_num_i  in  INT_BITS  classifier predicted digit
fc_rdy_i  in  1  classifier one-cycle result strobe
res_valid_o  out  1  result available
res_ready_i  in  1  result consumer ready
res_num_o  out  INT_BITS  captured digit
frame_err_o  out  1  one-cycle pulse: malformed frame dropped
busy_o  out  1  launcher not IDLE

Behaviour:
- Reset (synchronous, rst_n=0): all outputs 0; pix_cnt=0; frame_full=0; launcher=IDLE. Reset mid-burst abandons the burst; the frame buffer contents become don't-care.
- Collector:
  - Frame buffer is WIDTH x (INT_BITS+FRC_BITS); pixels are stored already converted.
  - s_pix_ready_o = !frame_full & (launcher != BURST).
  - On each accepted pixel: buf[pix_cnt] <= conv(data); pix_cnt increments.
  - Accept at pix_cnt==WIDTH-1 with last=1: frame_full <= 1, pix_cnt <= 0.
  - Accept with last=1 at pix_cnt != WIDTH-1, or last=0 at pix_cnt==WIDTH-1: frame_err_o pulses next cycle, pix_cnt <= 0, frame_full stays 0 (frame dropped).
- Conversion (default): conv = {INT_BITS'0, pix, (FRC_BITS-PIX_W)'0}, i.e. pix/2^PIX_W in [0,1).
- Launcher FSM: IDLE -> PREP -> BURST -> WAIT -> IDLE.
  - IDLE: go to PREP when frame_full & !res_valid_o. This ensures a result can never be overwritten.
  - PREP: one cycle; issues buffer read of address 0 (synchronous-read RAM); fc outputs stay 0.
  - BURST: lasts exactly WIDTH cycles, k=0..WIDTH-1. Cycle k: fc_x_o=k, fc_din_o=buf[k], fc_start_o=(k==0). Addresses are strictly consecutive with no gaps. In the final cycle (k==WIDTH-1), frame_full <= 0; collection may resume the following cycle.
  - WAIT: fc outputs 0. On fc_rdy_i: res_num_o <= fc_num_i, res_valid_o <= 1, go to IDLE.
  - fc_rdy_i outside WAIT is ignored.
- Result port: res_valid_o stays high and res_num_o stable until res_valid_o&res_ready_i; res_valid_o clears the next cycle.
- busy_o = (launcher != IDLE).
- Latency: last pixel accepted -> fc_start_o high = 2 cycles (frame_full set, then PREP), provided the result slot is empty.
- Simultaneous events:
  - Result handshake completing in the same cycle IDLE checks res_valid_o: launch waits one more cycle.
  - Pixel acceptance during WAIT into the freed buffer is legal.

Optional Feature:
FC_IMG_SIGNED_NORM_EN. When defined, the conversion maps pixels to [-1,1): conv = sign_extend((pix - 2^(PIX_W-1)) << (FRC_BITS-PIX_W+1)). Example with PIX_W=8, FRC_BITS=8: pixel 0 -> 0xFF00 (-1.0); 128 -> 0x0000; 255 -> 0x00FE. When undefined, the [0,1) mapping above applies.

Test Plan:
- WIDTH=16: stream pixels 0..15 (last on 15), no backpressure -> fc_start_o high with fc_x_o=0, then fc_x_o=1..15 on consecutive cycles; fc_din_o for pixel 15 = 0x000F<<0 with FRC=8, i.e. 0x000F.
- Pulse fc_rdy_i with fc_num_i=7 in WAIT, res_ready_i=0 -> res_valid_o=1, res_num_o=7, held 5 cycles; raising res_ready_i -> res_valid_o=0 the next cycle.
- Second frame fully collected while res_valid_o=1 -> no fc_start_o until the result is consumed; fc_start_o asserts 2 cycles after the handshake.
- Error cases: last on the 10th pixel -> frame_err_o one pulse, no burst. 16th pixel without last -> frame_err_o pulse. A following good frame bursts normally.
- Assert rst_n=0 at burst cycle k=5 -> all outputs 0 next cycle; a fresh frame afterwards bursts from x=0 with a single start pulse.
- With FC_IMG_SIGNED_NORM_EN, pixels 0/128/255 -> fc_din_o 0xFF00/0x0000/0x00FE.
